// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: per-register pending-write scoreboard with RUN/HOLD/DRAIN sequencing.
// Latency: zero-cycle issue decision; busy_o/err_o/state_o/drain_done_o are registered.
// Backpressure: stall_o holds ID on RAW hazard, full counter, stall_i, flush or drain.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   issue_valid_i             decoded instruction present in ID
//   rd_addr_i / rs_addr_i     destination / source register addresses
//   rd_use_i / rs_use_i       instruction reads rd / rs as operands
//   wr_en_i                   instruction writes rd (reserve request)
//   stall_i, flush_i          next-stage stall, single-cycle flush pulse
//   wb_i, wb_r_i              write-back valid and register address
//   issue_o, stall_o          instruction accepted / ID must hold (combinational)
//   reserve_o                 register reserve request (issue_o & wr_en_i)
//   busy_o                    per-register pending-write flag (registered)
//   drain_done_o              one-cycle pulse when a flush drain completes
//   err_o                     sticky: write-back to a register with no pending write
//   state_o                   FSM state (RUN=0, HOLD=1, DRAIN=2)
//
// Optional feature macro: HAZARD_SCOREBOARD_BYPASS_EN
//   When defined, a source whose only pending write retires this cycle is not treated as
//   busy (the register file forwards the WB data), removing one stall cycle per RAW hazard.

module hazard_scoreboard #(
  parameter  int N_REG = 16,
  parameter  int W_CNT = 2,
  localparam int AW    = $clog2(N_REG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid_i,
  input  logic [AW-1:0]    rd_addr_i,
  input  logic [AW-1:0]    rs_addr_i,
  input  logic             rd_use_i,
  input  logic             rs_use_i,
  input  logic             wr_en_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             wb_i,
  input  logic [AW-1:0]    wb_r_i,
  output logic             issue_o,
  output logic             stall_o,
  output logic             reserve_o,
  output logic [N_REG-1:0] busy_o,
  output logic             drain_done_o,
  output logic             err_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [W_CNT-1:0] CNT_MAX = {W_CNT{1'b1}};
  localparam logic [W_CNT-1:0] CNT_ONE = W_CNT'(1);

  logic [W_CNT-1:0] cnt [N_REG];
  logic [N_REG-1:0] busy;
  logic [N_REG-1:0] busy_eff;
  logic [N_REG-1:0] inc_vec;
  logic [N_REG-1:0] dec_vec;
  logic             hz;
  logic             all_zero;
  state_t           state;
  state_t           state_n;

  always_comb begin
    for (int r = 0; r < N_REG; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

`ifdef HAZARD_SCOREBOARD_BYPASS_EN
  // A register whose last outstanding write is retiring right now can be read this cycle.
  always_comb begin
    for (int r = 0; r < N_REG; r++) begin
      busy_eff[r] = busy[r] & ~(wb_i & (wb_r_i == AW'(r)) & (cnt[r] == CNT_ONE));
    end
  end
`else
  assign busy_eff = busy;
`endif

  // The full-counter term uses the registered count: a same-cycle write-back does not
  // free a slot until the next cycle, so the counter can never wrap.
  assign hz = (rd_use_i & busy_eff[rd_addr_i])
            | (rs_use_i & busy_eff[rs_addr_i])
            | (wr_en_i & (cnt[rd_addr_i] == CNT_MAX))
            | stall_i;

  assign issue_o   = ~rst & issue_valid_i & ~hz & (state != DRAIN) & ~flush_i;
  assign stall_o   = ~rst & issue_valid_i & ~issue_o;
  assign reserve_o = issue_o & wr_en_i;
  assign all_zero  = ~|busy;
  assign busy_o    = busy;
  assign state_o   = state;

  // Decrement only when something is pending; a stray write-back only raises err_o.
  always_comb begin
    for (int r = 0; r < N_REG; r++) begin
      inc_vec[r] = reserve_o & (rd_addr_i == AW'(r));
      dec_vec[r] = wb_i & (wb_r_i == AW'(r)) & busy[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N_REG; r++) begin
        cnt[r] <= '0;
      end
      err_o <= 1'b0;
    end else begin
      for (int r = 0; r < N_REG; r++) begin
        if (inc_vec[r] & ~dec_vec[r]) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec_vec[r] & ~inc_vec[r]) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
      if (wb_i & ~busy[wb_r_i]) begin
        err_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      drain_done_o <= 1'b0;
    end else begin
      state        <= state_n;
      drain_done_o <= (state == DRAIN) & ~flush_i & all_zero;
    end
  end

  // Flush wins over everything, including an in-progress drain.
  always_comb begin
    state_n = state;
    if (flush_i) begin
      state_n = DRAIN;
    end else begin
      case (state)
        RUN:     if (issue_valid_i & hz) state_n = HOLD;
        HOLD:    if (issue_o | ~issue_valid_i) state_n = RUN;
        DRAIN:   if (all_zero) state_n = RUN;
        default: state_n = RUN;
      endcase
    end
  end

endmodule
